// File: rtl/buffer_pkg.sv
// Shared types and helpers for the circular-buffer read-side drain stage.
// Define UNPACK_MSB_FIRST_EN to emit each group from its highest word down.
package buffer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef UNPACK_MSB_FIRST_EN
  localparam bit MsbFirst = 1'b1;
`else
  localparam bit MsbFirst = 1'b0;
`endif

  // Maps the serial position within a group to the held word it emits.
  function automatic int unsigned word_sel(input int unsigned idx,
                                           input int unsigned last);
    return MsbFirst ? (last - idx) : idx;
  endfunction

endpackage

// File: rtl/word_hold.sv
// J x WIDTH load-enabled hold register with an indexed combinational read port.
module word_hold #(
  parameter int WIDTH    = 8,
  parameter int J        = 4,
  parameter int CNT_BITS = $clog2(J) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_i,
  input  logic [WIDTH*J-1:0]   data_i,
  input  logic [CNT_BITS-1:0]  sel_i,
  output logic [WIDTH-1:0]     word_o
);

  logic [WIDTH-1:0] mem_q [J];

  // NOTE: the hold words are small and architecturally visible at reset, so
  // they are cleared like ordinary flops rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < J; i++) mem_q[i] <= '0;
    end else if (ld_i) begin
      for (int i = 0; i < J; i++) mem_q[i] <= data_i[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    word_o = '0;
    for (int i = 0; i < J; i++) begin
      if (sel_i == CNT_BITS'(i)) word_o = mem_q[i];
    end
  end

endmodule

// File: rtl/buffer_drain.sv
// Read-side drain: takes J-word groups from the buffer and serialises them.
// Word order within a group is reversed when UNPACK_MSB_FIRST_EN is defined.
module buffer_drain
  import buffer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int J        = 4,
  parameter int CNT_BITS = $clog2(J) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                empty,
  input  logic [WIDTH*J-1:0]  buf_data,
  input  logic                clr,
  output logic                rd_adv,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] idx_q, idx_d;
  logic                load;
  logic                xfer;
  logic                last;
  logic [CNT_BITS-1:0] sel;
  logic [WIDTH-1:0]    word;

  assign xfer = (state_q == SHIFT) && out_ready;
  assign last = (idx_q == CNT_BITS'(J - 1));

  // NOTE: every variable is given a default before any branch so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    if (clr) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            load    = 1'b1;
            state_d = SHIFT;
            idx_d   = '0;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (!last) begin
              idx_d = idx_q + CNT_BITS'(1);
            end else if (!empty) begin
              load  = 1'b1;
              idx_d = '0;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign sel = CNT_BITS'(word_sel(int'(idx_q), J - 1));

  word_hold #(
    .WIDTH    (WIDTH),
    .J        (J),
    .CNT_BITS (CNT_BITS)
  ) u_word_hold (
    .clk    (clk),
    .rst    (rst),
    .ld_i   (load),
    .data_i (buf_data),
    .sel_i  (sel),
    .word_o (word)
  );

  // rd_adv is combinational from empty; held low while reset is asserted.
  assign rd_adv    = load & rst;
  assign out_valid = (state_q == SHIFT);
  assign out_data  = out_valid ? word : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_buffer_drain.sv
// Self-checking bench for buffer_drain: queue-based reference model plus
// directed scenarios with literal expectations (honours UNPACK_MSB_FIRST_EN).
module tb_buffer_drain;

  localparam int WIDTH    = 8;
  localparam int J        = 4;
  localparam int CNT_BITS = $clog2(J) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               empty;
  logic [WIDTH*J-1:0] buf_data;
  logic               clr;
  logic               rd_adv;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] got[$];

  buffer_drain #(
    .WIDTH    (WIDTH),
    .J        (J),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .buf_data  (buf_data),
    .clr       (clr),
    .rd_adv    (rd_adv),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the words still owed to the consumer, in emission order.
  function automatic logic m_valid();
    return rst && (m_q.size() > 0);
  endfunction

  function automatic logic m_rd();
    return rst && !clr && !empty &&
           ((m_q.size() == 0) || (m_q.size() == 1 && out_ready));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
    end else if (clr) begin
      m_q.delete();
    end else if (m_rd()) begin
      m_q.delete();
      for (int i = 0; i < J; i++) begin
`ifdef UNPACK_MSB_FIRST_EN
        m_q.push_back(buf_data[(J-1-i)*WIDTH +: WIDTH]);
`else
        m_q.push_back(buf_data[i*WIDTH +: WIDTH]);
`endif
      end
    end else if (m_valid() && out_ready) begin
      void'(m_q.pop_front());
    end
  end

  always @(negedge clk) begin
    check("rd_adv", rd_adv, m_rd());
    check("out_valid", out_valid, m_valid());
    check("busy", busy, m_valid());
    if (m_valid()) check("out_data", out_data, m_q[0]);
    if (rst && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  localparam logic [WIDTH*J-1:0] G1 = 32'h4433_2211;
  localparam logic [WIDTH*J-1:0] G2 = 32'h8877_6655;

  logic [WIDTH-1:0] exp_words [18];
  logic [47:0]      pat_ready;
  logic [47:0]      pat_empty;

  initial begin
`ifdef UNPACK_MSB_FIRST_EN
    exp_words = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44, 8'h33, 8'h22, 8'h11,
                  8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                  8'h44, 8'h33};
`else
    exp_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h11, 8'h22};
`endif
    rst = 1'b0; empty = 1'b0; clr = 1'b0; out_ready = 1'b1; buf_data = G1;

    // Reset held with data available: everything quiet.
    tick(); tick();
    mid();
    check("rst_rd_adv", rd_adv, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);

    // Release: rd_adv in the first cycle, data the next; single group.
    tick(); rst = 1'b1;
    mid(); check("rel_rd_adv", rd_adv, 1'b1);
    tick(); empty = 1'b1;
    mid();
    check("first_valid", out_valid, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
    check("first_word", out_data, 8'h44);
`else
    check("first_word", out_data, 8'h11);
`endif
    tick(); tick(); tick(); tick();
    mid(); check("single_idle_busy", busy, 1'b0);

    // Backpressure after the second word.
    tick(); empty = 1'b0;
    tick(); empty = 1'b1;
    tick(); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
`ifdef UNPACK_MSB_FIRST_EN
      check("bp_hold_data", out_data, 8'h33);
`else
      check("bp_hold_data", out_data, 8'h22);
`endif
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_no_rd_adv", rd_adv, 1'b0);
      if (i < 2) tick();
    end
    tick(); out_ready = 1'b1;
    tick(); tick(); tick();
    mid(); check("bp_idle_busy", busy, 1'b0);

    // Back-to-back groups with no bubble.
    tick(); empty = 1'b0; buf_data = G1;
    tick(); buf_data = G2;
    tick(); tick(); tick();
    mid();
    check("b2b_reload_rd_adv", rd_adv, 1'b1);
    check("b2b_reload_valid", out_valid, 1'b1);
    tick(); empty = 1'b1;
    mid(); check("b2b_no_bubble", out_valid, 1'b1);
    tick(); tick(); tick(); tick();
    mid(); check("b2b_idle_busy", busy, 1'b0);

    // clr coinciding with the second transfer, data still available.
    tick(); empty = 1'b0; buf_data = G1;
    tick(); empty = 1'b1;
    tick(); clr = 1'b1; empty = 1'b0;
    mid();
    check("clr_rd_adv", rd_adv, 1'b0);
    check("clr_valid", out_valid, 1'b1);
    tick(); clr = 1'b0; empty = 1'b1;
    mid();
    check("clr_after_valid", out_valid, 1'b0);
    check("clr_after_busy", busy, 1'b0);

    check("word_count", got.size(), 18);
    for (int i = 0; i < 18; i++) begin
      if (i < got.size()) check($sformatf("word_%0d", i), got[i], exp_words[i]);
    end

    // Mixed handshake / availability patterns, model-checked every cycle.
    pat_ready = 48'hB6D5_3A9F_E71C;
    pat_empty = 48'h0F03_C00F_30C0;
    for (int i = 0; i < 48; i++) begin
      tick();
      out_ready = pat_ready[i];
      empty     = pat_empty[i];
      clr       = (i == 30);
      buf_data  = {8'(i + 4), 8'(i + 3), 8'(i + 2), 8'(i + 1)};
    end
    tick(); clr = 1'b0; empty = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    mid(); check("final_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_drain.md
# buffer_drain

Downstream read-side stage for the K-in/J-out circular buffer datapath. When the buffer reports data, the block takes one J-word group from the buffer's parallel output. It pulses the buffer's read-pointer load and then emits the group one WIDTH-bit word at a time over a valid/ready handshake. It is the buffer's only consumer and owns the read-pointer advance (ld3) decision.

## Interface
- WIDTH, 8: bits per word
- J, 4: words per buffer read group; must be ≥1
- CNT_BITS, $clog2(J)+1: word-index counter width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset; all state cleared while low
- empty  input  1  from buffer: fewer than J words available
- buf_data  input  WIDTH*J  buffer parallel output at current read address; word i = bits [i*WIDTH +: WIDTH]
- clr  input  1  synchronous abort: drop held words, return to IDLE
- rd_adv  output  1  one-cycle pulse; drives buffer read-pointer load (ld3)
- out_data  output  WIDTH  current serial word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data when high with out_valid
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, SHIFT.
- IDLE, !empty, !clr: capture buf_data into the hold register, pulse rd_adv, set idx=0, go to SHIFT.
- IDLE, empty: stay in IDLE with rd_adv=0.
- SHIFT: out_valid=1. out_data = held word selected by idx.
- SHIFT, out_valid&&out_ready: the word is transferred. If idx<J-1, idx increments.
- SHIFT, transfer with idx==J-1 (last word):
  - if !empty: reload buf_data, pulse rd_adv, set idx=0, stay in SHIFT.
  - if empty: go to IDLE.
- SHIFT, !out_ready: hold out_data and idx; out_valid stays high and never drops before a transfer.
- clr has priority over everything in the cycle it is high:
  - next state is IDLE, idx=0, rd_adv=0 in that cycle.
  - a transfer coinciding with clr counts as delivered to the consumer; the remaining held words are discarded.
- rd_adv is never asserted while empty=1, and is asserted at most once per J transfers.
- idx wraps only through reload. No arithmetic overflow is possible because idx ≤ J-1 < 2^CNT_BITS.

## Timing
- Reset values: state=IDLE, idx=0, hold register=0, rd_adv=0, out_valid=0, out_data=0, busy=0.
- Load latency: empty falls at cycle n → rd_adv high in cycle n → out_valid high from cycle n+1.
- The capture of buf_data and the pointer advance use the same edge. empty is therefore current again by the next evaluation, which is ≥1 cycle later.
- Throughput: with out_ready held at 1 and the buffer never empty, there is one word per cycle with no bubble between groups.
- Reset mid-group: held words are lost. The pointer has already advanced past them, so this is accepted behaviour.

## Configuration
- UNPACK_MSB_FIRST_EN defined: each group is emitted from word J-1 down to word 0.
- Not defined: each group is emitted from word 0 up to word J-1.
- The macro affects only the word selection. Handshake, rd_adv timing and counts are identical in both modes.

## Structure
- Shared package buffer_pkg holds:
  - the state enum (IDLE, SHIFT)
  - the word-select helper function
- Sub-module word_hold: a J×WIDTH load-enabled register with asynchronous active-low clear and an indexed read port. The FSM and idx counter stay in buffer_drain.

## Test plan
- Reset: hold rst low with empty=0 → all outputs 0. Release → rd_adv pulses in the first cycle, out_valid=1 in the next.
- Single group, WIDTH=8, J=4: buf_data=0x44332211, out_ready=1, empty rises after the load → out_data 0x11,0x22,0x33,0x44 on consecutive cycles. Then IDLE with busy=0.
- Backpressure: out_ready low for 3 cycles after the second word → out_data stays 0x22 with out_valid=1. No rd_adv until the fourth transfer.
- Back-to-back: empty held 0 with groups 0x44332211 then 0x88776655 → 8 words with no bubble. rd_adv pulses in the same cycle as the 0x44 transfer.
- clr during SHIFT at idx=1, coinciding with a transfer → 0x22 counted. Next cycle state is IDLE, out_valid=0, no rd_adv in the clr cycle.
- UNPACK_MSB_FIRST_EN build with group 0x44332211 → order 0x44,0x33,0x22,0x11.
